// File: rtl/auto_nav_ctrl.sv
// auto_nav_ctrl: wall-following maze controller with dead-reckoned pose, a junction-mark
// ring buffer and loop escape (back off, then drive forward laying a barrier).
module auto_nav_ctrl #(
  parameter int  COORD_W        = 32,
  parameter int  TURN_TICKS     = 500,
  parameter int  BACK_TICKS     = 750,
  parameter int  FWD_TICKS      = 375,
  parameter int  SETTLE_TICKS   = 50,
  parameter int  REMARK_DELAY   = 1000,
  parameter int  LOOP_TOL_SHIFT = 5,
  parameter int  MARK_DEPTH     = 4,
  localparam int MC_W           = $clog2(MARK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               start,
  input  logic               hand_mode,
  input  logic [3:0]         detector,
  output logic               move_forward,
  output logic               move_backward,
  output logic               turn_left,
  output logic               turn_right,
  output logic               place_barrier_signal,
  output logic               loop_hit,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         heading,
  output logic [MC_W-1:0]    mark_count,
  output logic [3:0]         out_state
);
  localparam int T2      = 2 * TURN_TICKS;
  localparam int M1      = (T2 > BACK_TICKS) ? T2 : BACK_TICKS;
  localparam int M2      = (FWD_TICKS > REMARK_DELAY) ? FWD_TICKS : REMARK_DELAY;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = (MARK_DEPTH > 1) ? $clog2(MARK_DEPTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_DECIDE = 4'd1, S_TURN_L = 4'd2, S_TURN_R = 4'd3, S_TURN_BK = 4'd4,
    S_MOVE = 4'd5, S_BACK = 4'd6, S_PLACE = 4'd7, S_HALT = 4'd8
  } state_t;

  state_t               state_r, nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 hand_r, take_hit_s, hit_s, settled_s, commit_s;
  logic                 front_open_s, left_open_s, right_open_s, back_open_s;
  logic                 pref_s, alt_s, move_pref_s;
  logic [1:0]           dir_s, cand_h_r;
  logic [COORD_W-1:0]   cand_x_r, cand_y_r;
  logic [COORD_W-1:0]   mark_x_r [MARK_DEPTH];
  logic [COORD_W-1:0]   mark_y_r [MARK_DEPTH];
  logic [1:0]           mark_h_r [MARK_DEPTH];
  logic [MARK_DEPTH-1:0] mark_v_r;
  logic [PTR_W-1:0]     wr_ptr_r;

  function automatic logic near(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    logic [COORD_W-1:0] d;
    logic [COORD_W-1:0] m;
    d = a - b;
    m = d[COORD_W-1] ? (~d + COORD_W'(1)) : d;
    return (m >> LOOP_TOL_SHIFT) == '0;
  endfunction

  assign front_open_s = ~detector[3];
  assign left_open_s  = ~detector[2];
  assign right_open_s = ~detector[1];
  assign back_open_s  = ~detector[0];
  assign pref_s       = hand_mode ? left_open_s : right_open_s;
  assign alt_s        = hand_mode ? right_open_s : left_open_s;
  assign move_pref_s  = hand_r ? left_open_s : right_open_s;
  assign settled_s    = (cnt_r >= CNT_W'(SETTLE_TICKS));
  assign commit_s     = (state_r == S_MOVE) && (cnt_r == CNT_W'(REMARK_DELAY - 1));
  assign dir_s        = heading + ((state_r == S_BACK) ? 2'd2 : 2'd0);
  assign out_state    = state_r;

  // Parallel compare of the current pose against every valid mark.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < MARK_DEPTH; i++) begin
      hit_s = hit_s | (mark_v_r[i] & (mark_h_r[i] == heading) &
                       near(pos_x, mark_x_r[i]) & near(pos_y, mark_y_r[i]));
    end
  end

  // Next-state selection; a loop hit outranks the wall checks in MOVE.
  always_comb begin
    nxt_s      = state_r;
    take_hit_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) nxt_s = S_DECIDE;
        else       nxt_s = S_IDLE;
      end
      S_DECIDE: begin
        if (pref_s)            nxt_s = hand_mode ? S_TURN_L : S_TURN_R;
        else if (front_open_s) nxt_s = S_MOVE;
        else if (alt_s)        nxt_s = hand_mode ? S_TURN_R : S_TURN_L;
        else if (back_open_s)  nxt_s = S_TURN_BK;
        else                   nxt_s = S_HALT;
      end
      S_TURN_L, S_TURN_R: begin
        if (cnt_r == CNT_W'(TURN_TICKS - 1)) nxt_s = S_MOVE;
        else                                 nxt_s = state_r;
      end
      S_TURN_BK: begin
        if (cnt_r == CNT_W'(T2 - 1)) nxt_s = S_MOVE;
        else                         nxt_s = S_TURN_BK;
      end
      S_MOVE: begin
        if (settled_s && hit_s) begin
          nxt_s      = S_BACK;
          take_hit_s = 1'b1;
        end else if (settled_s && (!front_open_s || move_pref_s)) begin
          nxt_s = S_DECIDE;
        end else begin
          nxt_s = S_MOVE;
        end
      end
      S_BACK: begin
        if (cnt_r == CNT_W'(BACK_TICKS - 1)) nxt_s = S_PLACE;
        else                                 nxt_s = S_BACK;
      end
      S_PLACE: begin
        if (cnt_r == CNT_W'(FWD_TICKS - 1)) nxt_s = S_DECIDE;
        else                                nxt_s = S_PLACE;
      end
      S_HALT:  nxt_s = S_HALT;
      default: nxt_s = S_IDLE;
    endcase
  end

  // State register with command lines decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !enable) begin
      state_r              <= S_IDLE;
      move_forward         <= 1'b0;
      move_backward        <= 1'b0;
      turn_left            <= 1'b0;
      turn_right           <= 1'b0;
      place_barrier_signal <= 1'b0;
      loop_hit             <= 1'b0;
    end else begin
      state_r              <= nxt_s;
      move_forward         <= (nxt_s == S_MOVE) || (nxt_s == S_PLACE);
      move_backward        <= (nxt_s == S_BACK);
      turn_left            <= (nxt_s == S_TURN_L);
      turn_right           <= (nxt_s == S_TURN_R) || (nxt_s == S_TURN_BK);
      place_barrier_signal <= (nxt_s == S_PLACE);
      loop_hit             <= take_hit_s;
    end
  end

  // State timer, heading, dead-reckoned position and mark candidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !enable) begin
      cnt_r    <= '0;
      hand_r   <= 1'b0;
      heading  <= 2'd0;
      pos_x    <= '0;
      pos_y    <= '0;
      cand_x_r <= '0;
      cand_y_r <= '0;
      cand_h_r <= 2'd0;
    end else begin
      if (nxt_s != state_r)                                      cnt_r <= '0;
      else if (state_r == S_MOVE && cnt_r == CNT_W'(REMARK_DELAY)) cnt_r <= cnt_r;
      else if (state_r == S_IDLE || state_r == S_HALT)           cnt_r <= cnt_r;
      else                                                       cnt_r <= cnt_r + CNT_W'(1);
      if (state_r == S_DECIDE) begin
        hand_r <= hand_mode;
        case (nxt_s)
          S_TURN_L:  heading <= heading - 2'd1;
          S_TURN_R:  heading <= heading + 2'd1;
          S_TURN_BK: heading <= heading + 2'd2;
          default:   heading <= heading;
        endcase
      end
      if (state_r == S_MOVE || state_r == S_BACK) begin
        case (dir_s)
          2'd0:    pos_y <= pos_y + COORD_W'(1);
          2'd1:    pos_x <= pos_x + COORD_W'(1);
          2'd2:    pos_y <= pos_y - COORD_W'(1);
          default: pos_x <= pos_x - COORD_W'(1);
        endcase
      end
      if (nxt_s == S_MOVE && state_r != S_MOVE) begin
        cand_x_r <= pos_x;
        cand_y_r <= pos_y;
        cand_h_r <= heading;
      end
    end
  end

  // Mark ring buffer: commit overwrites the oldest slot, barrier placement wipes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !enable) begin
      mark_v_r   <= '0;
      wr_ptr_r   <= '0;
      mark_count <= '0;
      for (int i = 0; i < MARK_DEPTH; i++) begin
        mark_x_r[i] <= '0;
        mark_y_r[i] <= '0;
        mark_h_r[i] <= 2'd0;
      end
    end else if (state_r == S_PLACE && nxt_s == S_DECIDE) begin
      mark_v_r   <= '0;
      wr_ptr_r   <= '0;
      mark_count <= '0;
    end else if (commit_s) begin
      mark_x_r[wr_ptr_r] <= cand_x_r;
      mark_y_r[wr_ptr_r] <= cand_y_r;
      mark_h_r[wr_ptr_r] <= cand_h_r;
      mark_v_r[wr_ptr_r] <= 1'b1;
      wr_ptr_r <= (wr_ptr_r == PTR_W'(MARK_DEPTH - 1)) ? '0 : wr_ptr_r + PTR_W'(1);
      if (mark_count != MC_W'(MARK_DEPTH)) mark_count <= mark_count + MC_W'(1);
    end
  end
endmodule

// File: tb/tb_auto_nav_ctrl.sv
// Bench for auto_nav_ctrl: lockstep behavioural model checked every cycle, a DECIDE vector
// table, directed multi-cycle sequences and a randomized phase.
module tb_auto_nav_ctrl;
  localparam int CW = 32, TT = 500, BT = 750, FT = 375, ST = 50, RD = 1000, LS = 5, MD = 4;
  localparam int TOL = 1 << LS;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, start = 1'b0, hand_mode = 1'b0;
  logic [3:0] detector = 4'b1111;
  logic move_forward, move_backward, turn_left, turn_right, place_barrier_signal, loop_hit;
  logic [CW-1:0] pos_x, pos_y;
  logic [1:0] heading;
  logic [2:0] mark_count;
  logic [3:0] out_state;

  auto_nav_ctrl #(.COORD_W(CW), .TURN_TICKS(TT), .BACK_TICKS(BT), .FWD_TICKS(FT),
                  .SETTLE_TICKS(ST), .REMARK_DELAY(RD), .LOOP_TOL_SHIFT(LS), .MARK_DEPTH(MD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .hand_mode(hand_mode),
    .detector(detector), .move_forward(move_forward), .move_backward(move_backward),
    .turn_left(turn_left), .turn_right(turn_right), .place_barrier_signal(place_barrier_signal),
    .loop_hit(loop_hit), .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
    .mark_count(mark_count), .out_state(out_state));

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  // Reference model: states by name-number, time spent in state, marks as a FIFO of poses.
  typedef struct { int x; int y; int h; } mark_t;
  mark_t marks[$];
  mark_t cand;
  int m_state, m_time, m_x, m_y, m_head;
  bit m_hand, m_hit;
  int dxs[4] = '{0, 1, 0, -1};
  int dys[4] = '{1, 0, -1, 0};

  function automatic void model_reset();
    m_state = 0; m_time = 0; m_x = 0; m_y = 0; m_head = 0; m_hand = 0; m_hit = 0;
    marks.delete();
  endfunction

  function automatic void enter(int s);
    m_state = s;
    m_time  = 0;
    if (s == 5) cand = '{m_x, m_y, m_head};
  endfunction

  function automatic bit near_mark(int x, int y, int h);
    foreach (marks[i]) begin
      int dx, dy;
      dx = x - marks[i].x;
      dy = y - marks[i].y;
      if (marks[i].h == h && dx > -TOL && dx < TOL && dy > -TOL && dy < TOL) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    int el, d;
    bit fo, lo, ro, bo, pref, alt, hit;
    m_hit = 1'b0;
    if (!enable) begin model_reset(); return; end
    el = m_time; m_time++;
    fo = !detector[3]; lo = !detector[2]; ro = !detector[1]; bo = !detector[0];
    case (m_state)
      0: if (start) enter(1);
      1: begin
        m_hand = hand_mode;
        pref = hand_mode ? lo : ro;
        alt  = hand_mode ? ro : lo;
        if (pref) begin
          m_head = (m_head + (hand_mode ? 3 : 1)) % 4; enter(hand_mode ? 2 : 3);
        end else if (fo) enter(5);
        else if (alt) begin
          m_head = (m_head + (hand_mode ? 1 : 3)) % 4; enter(hand_mode ? 3 : 2);
        end else if (bo) begin
          m_head = (m_head + 2) % 4; enter(4);
        end else enter(8);
      end
      2, 3: if (el + 1 == TT) enter(5);
      4: if (el + 1 == 2 * TT) enter(5);
      5: begin
        hit = (el >= ST) && near_mark(m_x, m_y, m_head);
        m_x += dxs[m_head]; m_y += dys[m_head];
        if (el + 1 == RD) begin
          marks.push_back(cand);
          if (marks.size() > MD) void'(marks.pop_front());
        end
        if (el >= ST) begin
          if (hit) begin m_hit = 1'b1; enter(6); end
          else if (!fo || (m_hand ? lo : ro)) enter(1);
        end
      end
      6: begin
        d = (m_head + 2) % 4;
        m_x += dxs[d]; m_y += dys[d];
        if (el + 1 == BT) enter(7);
      end
      7: if (el + 1 == FT) begin marks.delete(); enter(1); end
      default: ;
    endcase
  endtask

  task automatic check_all();
    logic [5:0] exp_mot, act_mot;
    logic [31:0] ex, ey;
    exp_mot = {m_state == 5 || m_state == 7, m_state == 6, m_state == 2,
               m_state == 3 || m_state == 4, m_state == 7, m_hit};
    act_mot = {move_forward, move_backward, turn_left, turn_right, place_barrier_signal, loop_hit};
    ex = m_x; ey = m_y;
    n_checks++;
    if (out_state !== 4'(m_state) || act_mot !== exp_mot || pos_x !== ex || pos_y !== ey ||
        heading !== 2'(m_head) || mark_count !== 3'(marks.size())) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL lockstep t=%0t state=%0d want %0d cmds=%b want %b pos=(%0d,%0d) want (%0d,%0d) head=%0d want %0d marks=%0d want %0d",
                 $time, out_state, m_state, act_mot, exp_mot, $signed(pos_x), $signed(pos_y),
                 m_x, m_y, heading, m_head, mark_count, marks.size());
    end
  endtask

  task automatic check_val(string name, logic signed [63:0] act, logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      check_all();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; start = 1'b0; detector = 4'b1111; hand_mode = 1'b0;
    model_reset();
    #1; check_all();
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
  endtask

  // Synchronous clear, then start and enter DECIDE.
  task automatic restart();
    enable = 1'b0; tick(); enable = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic drive_south_to(int y_stop);
    int g = 0;
    while ($signed(pos_y) > y_stop && g < 8000) begin tick(); g++; end
    check_val("reach_south", $signed(pos_y) <= y_stop, 1);
  endtask

  task automatic run_loop(bit abort_in_place);
    int g, cnt, y_exp;
    restart();
    hand_mode = 1'b0; detector = 4'b0010; tick();
    detector = 4'b0110; tick(1100);
    check_val("loop_first_mark", mark_count, 1);
    detector = 4'b1110; tick(2 + 2 * TT);
    check_val("loop_heading_s", heading, 2);
    detector = 4'b0110; drive_south_to(-40);
    detector = 4'b1110; tick(2 + 2 * TT);
    detector = 4'b0110;
    g = 0;
    while (!loop_hit && g < 300) begin tick(); g++; end
    check_val("loop_hit_pulse", loop_hit, 1);
    check_val("loop_back_state", out_state, 6);
    check_val("loop_marks_at_hit", mark_count, 2);
    y_exp = m_y - BT;
    cnt = 0;
    while (move_backward && cnt < 3000) begin cnt++; tick(); end
    check_val("back_len", cnt, BT);
    check_val("back_pos_y", $signed(pos_y), y_exp);
    if (abort_in_place) begin
      tick(100);
      rst_n = 1'b0; #1;
      check_val("abort_cmds", {move_forward, move_backward, turn_left, turn_right,
                               place_barrier_signal, loop_hit}, 0);
      check_val("abort_state", out_state, 0);
      check_val("abort_pos_y", $signed(pos_y), 0);
      do_reset();
    end else begin
      cnt = 0;
      while (place_barrier_signal && cnt < 3000) begin cnt++; tick(); end
      check_val("place_len", cnt, FT);
      check_val("place_marks_cleared", mark_count, 0);
      check_val("place_to_decide", out_state, 1);
    end
  endtask

  typedef struct { bit hand; logic [3:0] det; int exp_state; int exp_head; } dvec_t;
  dvec_t vt[12];

  initial begin
    int cnt, hold;
    vt[0]  = '{1'b0, 4'b1100, 3, 1};
    vt[1]  = '{1'b0, 4'b1110, 4, 2};
    vt[2]  = '{1'b0, 4'b0000, 3, 1};
    vt[3]  = '{1'b1, 4'b0000, 2, 3};
    vt[4]  = '{1'b0, 4'b0010, 5, 0};
    vt[5]  = '{1'b1, 4'b0100, 5, 0};
    vt[6]  = '{1'b0, 4'b1010, 2, 3};
    vt[7]  = '{1'b1, 4'b1100, 3, 1};
    vt[8]  = '{1'b0, 4'b1111, 8, 0};
    vt[9]  = '{1'b1, 4'b1111, 8, 0};
    vt[10] = '{1'b1, 4'b1101, 3, 1};
    vt[11] = '{1'b0, 4'b1011, 2, 3};

    do_reset();
    check_val("reset_state", out_state, 0);
    check_val("reset_pos_x", $signed(pos_x), 0);

    foreach (vt[i]) begin
      restart();
      hand_mode = vt[i].hand; detector = vt[i].det; tick();
      check_val($sformatf("decide%0d_state", i), out_state, vt[i].exp_state);
      check_val($sformatf("decide%0d_heading", i), heading, vt[i].exp_head);
    end

    // Right turn timing, then MOVE.
    restart();
    hand_mode = 1'b0; detector = 4'b1100; tick();
    cnt = 0;
    while (turn_right && cnt < 3000) begin cnt++; tick(); end
    check_val("turn_r_len", cnt, TT);
    check_val("turn_r_then_move", out_state, 5);
    check_val("turn_r_heading", heading, 1);

    // Turn-back timing and enable drop mid-turn.
    restart();
    detector = 4'b1110; tick();
    cnt = 0;
    while (turn_right && cnt < 3000) begin cnt++; tick(); end
    check_val("turn_bk_len", cnt, 2 * TT);
    restart();
    detector = 4'b1110; tick(10);
    enable = 1'b0; tick(); enable = 1'b1;
    check_val("en_drop_turn", turn_right, 0);
    check_val("en_drop_state", out_state, 0);

    // HALT holds until cleared.
    restart();
    detector = 4'b1111; tick();
    for (int k = 0; k < 200; k++) begin detector = 4'($urandom); tick(); end
    check_val("halt_state", out_state, 8);
    check_val("halt_motion", {move_forward, move_backward, turn_left, turn_right}, 0);
    enable = 1'b0; tick(); enable = 1'b1;
    check_val("halt_cleared", out_state, 0);

    // 100 cycles north.
    restart();
    detector = 4'b0010; tick();
    detector = 4'b0110; tick(100);
    check_val("north100_y", $signed(pos_y), 100);
    check_val("north100_x", $signed(pos_x), 0);

    run_loop(1'b0);
    run_loop(1'b1);

    // Five commits into four slots; the oldest (origin) must no longer trigger a loop.
    restart();
    hand_mode = 1'b0; detector = 4'b0010; tick();
    for (int r = 0; r < MD + 1; r++) begin
      detector = 4'b0110; tick(RD + 10);
      detector = 4'b0100; tick();
      detector = 4'b0010; tick();
    end
    check_val("marks_saturate", mark_count, MD);
    detector = 4'b1110; tick(2 + 2 * TT);
    detector = 4'b0110; drive_south_to(-40);
    detector = 4'b1110; tick(2 + 2 * TT);
    detector = 4'b0110; tick(ST + 100);
    check_val("oldest_overwritten", out_state, 5);

    // Randomized phase against the model.
    enable = 1'b0; tick(); enable = 1'b1;
    hold = 0;
    for (int k = 0; k < 15000; k++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 9) == 0) detector = 4'b1111;
        else detector = 4'($urandom) & 4'b1110;
        hand_mode = 1'($urandom);
        start = 1'($urandom);
        hold = $urandom_range(1, 400);
      end
      hold--;
      enable = ($urandom_range(0, 1999) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
